// File: rtl/dt_pkg.sv
// Shared definitions for the seven-segment readback path: segment codes,
// field widths and the one-hot selector check.
package dt_pkg;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  // Patterns are written abcdefg, so index 0 of a [0:6] vector is segment a.
  localparam logic [0:SEG_W-1] SEG_0 = 7'b1111110;
  localparam logic [0:SEG_W-1] SEG_1 = 7'b0110000;
  localparam logic [0:SEG_W-1] SEG_2 = 7'b1101101;
  localparam logic [0:SEG_W-1] SEG_3 = 7'b1111001;
  localparam logic [0:SEG_W-1] SEG_4 = 7'b0110011;
  localparam logic [0:SEG_W-1] SEG_5 = 7'b1011011;
  localparam logic [0:SEG_W-1] SEG_6 = 7'b1011111;
  localparam logic [0:SEG_W-1] SEG_7 = 7'b1110000;
  localparam logic [0:SEG_W-1] SEG_8 = 7'b1111111;
  localparam logic [0:SEG_W-1] SEG_9 = 7'b1111011;
  localparam logic [0:SEG_W-1] SEG_A = 7'b1110111;
  localparam logic [0:SEG_W-1] SEG_B = 7'b0011111;
  localparam logic [0:SEG_W-1] SEG_C = 7'b1001110;
  localparam logic [0:SEG_W-1] SEG_D = 7'b0111101;
  localparam logic [0:SEG_W-1] SEG_E = 7'b1001111;
  localparam logic [0:SEG_W-1] SEG_F = 7'b1000111;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/dt_scan_decoder_if.sv
// Display bus as seen by the readback decoder: segment/select lines in,
// captured digits and status out.
interface dt_scan_decoder_if #(parameter int DIGITS = 8);

  logic [0:dt_pkg::SEG_W-1] seg;
  logic [DIGITS-1:0]        sel;
  logic                     clear;
  logic [4*DIGITS-1:0]      value;
  logic [DIGITS-1:0]        digit_valid;
  logic                     frame_done;
  logic                     err;
  logic [2:0]               err_digit;

  modport master (
    output seg, sel, clear,
    input  value, digit_valid, frame_done, err, err_digit
  );

  modport slave (
    input  seg, sel, clear,
    output value, digit_valid, frame_done, err, err_digit
  );

endinterface

// File: rtl/dt_decoder.sv
// Inverse of the hex-to-segment encoder; anything outside the table,
// including all-off, is reported as not legal.
module dt_decoder
  import dt_pkg::*;
(
  input  logic [0:SEG_W-1]    seg,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                legal
);

  always_comb begin
    nibble = '0;
    legal  = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/dt_scan_decoder.sv
// Watches a multiplexed seven-segment bus, debounces each digit and decodes
// it back into hex nibbles, with frame completion and illegal-pattern flags.
module dt_scan_decoder
  import dt_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  dt_scan_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [0:SEG_W-1]    last_seg;
  logic [DIGITS-1:0]   last_sel;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic                onehot;
  logic                same;
  logic                commit;
  logic                legal;
  logic [NIBBLE_W-1:0] nibble;
  logic [2:0]          sel_idx;

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   digit_valid_q;
  logic                frame_done_q;
  logic                err_q;
  logic [2:0]          err_digit_q;

  assign onehot = is_onehot(8'(bus.sel));
  assign same   = onehot && (bus.seg == last_seg) && (bus.sel == last_sel);
  // Commit only on the edge that reaches the threshold, never while saturated.
  assign commit = same && (cnt == CNT_MAX - 1'b1);

  always_comb begin
    cnt_next = '0;
    if (same)
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    else if (onehot)
      cnt_next = CNT_W'(1);
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bus.sel[i]) sel_idx = 3'(i);
  end

  dt_decoder u_dec (
    .seg    (bus.seg),
    .nibble (nibble),
    .legal  (legal)
  );

  // Frame wrap runs before the commit so a same-edge commit bit survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_seg      <= '0;
      last_sel      <= '0;
      cnt           <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      err_digit_q   <= '0;
    end else begin
      last_seg     <= bus.seg;
      last_sel     <= bus.sel;
      cnt          <= cnt_next;
      frame_done_q <= 1'b0;
      if (bus.clear) begin
        digit_valid_q <= '0;
        err_q         <= 1'b0;
      end else begin
        if (digit_valid_q == '1) begin
          frame_done_q  <= 1'b1;
          digit_valid_q <= '0;
        end
        if (commit) begin
          if (legal) begin
            value_q[4*sel_idx +: NIBBLE_W] <= nibble;
            digit_valid_q[sel_idx]         <= 1'b1;
          end else begin
            err_q       <= 1'b1;
            err_digit_q <= sel_idx;
          end
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;
  assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_dt_scan_decoder.sv
// Directed and randomized checks of dt_scan_decoder against a run-length
// reference model of the display bus.
module tb_dt_scan_decoder;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   fdSeen = 0;

  dt_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  dt_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [0:6] segCode [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: run length of identical one-hot samples, per-digit arrays.
  int         runLen;
  logic [0:6] prevSeg;
  logic [7:0] prevSel;
  int         mValue [DIGITS];
  bit         mValid [DIGITS];
  bit         mFrame;
  bit         mErr;
  int         mErrDigit;

  task automatic resetModel();
    runLen = 0; prevSeg = '0; prevSel = '0;
    for (int i = 0; i < DIGITS; i++) begin mValue[i] = 0; mValid[i] = 0; end
    mFrame = 0; mErr = 0; mErrDigit = 0;
  endtask

  task automatic modelEdge(input logic [0:6] s, input logic [7:0] d, input logic c);
    bit oneHot, allValid;
    int idx, code;
    oneHot = $onehot(d);
    if (oneHot && s == prevSeg && d == prevSel) runLen++;
    else runLen = oneHot ? 1 : 0;
    prevSeg = s; prevSel = d;
    allValid = 1;
    for (int i = 0; i < DIGITS; i++) if (!mValid[i]) allValid = 0;
    mFrame = 0;
    if (c) begin
      for (int i = 0; i < DIGITS; i++) mValid[i] = 0;
      mErr = 0;
    end else begin
      if (allValid) begin
        mFrame = 1;
        for (int i = 0; i < DIGITS; i++) mValid[i] = 0;
      end
      if (runLen == STABLE) begin
        idx = 0;
        for (int i = 0; i < DIGITS; i++) if (d[i]) idx = i;
        code = -1;
        for (int n = 0; n < 16; n++) if (segCode[n] == s) code = n;
        if (code >= 0) begin mValue[idx] = code; mValid[idx] = 1; end
        else begin mErr = 1; mErrDigit = idx; end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] expValue;
    logic [7:0]  expValid;
    expValue = '0; expValid = '0;
    for (int i = 0; i < DIGITS; i++) begin
      expValue[4*i +: 4] = 4'(mValue[i]);
      expValid[i] = mValid[i];
    end
    if (bus.frame_done === 1'b1) fdSeen++;
    check({tag, ".value"}, bus.value, expValue);
    check({tag, ".digit_valid"}, 32'(bus.digit_valid), 32'(expValid));
    check({tag, ".frame_done"}, 32'(bus.frame_done), 32'(mFrame));
    check({tag, ".err"}, 32'(bus.err), 32'(mErr));
    check({tag, ".err_digit"}, 32'(bus.err_digit), 32'(mErrDigit));
    check({tag, ".cnt"}, 32'(dut.cnt), 32'((runLen > STABLE) ? STABLE : runLen));
  endtask

  task automatic applyStimulus(input string tag, input logic [0:6] s, input logic [7:0] d,
                               input logic c, input int n);
    for (int k = 0; k < n; k++) begin
      bus.seg = s; bus.sel = d; bus.clear = c;
      @(posedge clk);
      modelEdge(s, d, c);
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    logic [0:6] rs;
    logic [7:0] rd;
    logic       rc;
    rst_n = 1'b0;
    bus.seg = '0; bus.sel = '0; bus.clear = 1'b0;
    resetModel();
    #12;
    checkOutput("reset");
    rst_n = 1'b1;

    // Glitch reject: a short "1" on digit 2 must never land.
    applyStimulus("glitch1", segCode[1], 8'h04, 1'b0, 3);
    applyStimulus("glitch0", segCode[0], 8'h04, 1'b0, 3);
    check("glitch.pre_commit_valid", 32'(bus.digit_valid[2]), 32'd0);
    applyStimulus("glitch0", segCode[0], 8'h04, 1'b0, 1);
    check("glitch.commit_valid", 32'(bus.digit_valid[2]), 32'd1);
    check("glitch.nibble", 32'(bus.value[11:8]), 32'd0);

    fdSeen = 0;
    for (int i = 0; i < DIGITS; i++)
      applyStimulus("static", segCode[i + 2], 8'(1 << i), 1'b0, STABLE);
    check("static.value", bus.value, 32'h98765432);
    applyStimulus("static_idle", segCode[8], 8'h00, 1'b0, 1);
    check("static.frame_pulse", 32'(bus.frame_done), 32'd1);
    check("static.valid_cleared", 32'(bus.digit_valid), 32'd0);
    applyStimulus("static_idle", segCode[8], 8'h00, 1'b0, 2);
    check("static.frame_count", 32'(fdSeen), 32'd1);

    applyStimulus("illegal", 7'b0000001, 8'h10, 1'b0, STABLE);
    check("illegal.err", 32'(bus.err), 32'd1);
    check("illegal.err_digit", 32'(bus.err_digit), 32'd4);
    check("illegal.valid4", 32'(bus.digit_valid[4]), 32'd0);
    check("illegal.nibble4", 32'(bus.value[19:16]), 32'd6);

    applyStimulus("selclear", segCode[8], 8'h00, 1'b1, 1);
    applyStimulus("sel_none", segCode[8], 8'h00, 1'b0, 10);
    applyStimulus("sel_multi", segCode[8], 8'h03, 1'b0, 10);
    check("selfault.err", 32'(bus.err), 32'd0);
    check("selfault.cnt", 32'(dut.cnt), 32'd0);

    // Clear lands on the commit edge of the last digit of a frame.
    fdSeen = 0;
    for (int i = 0; i < DIGITS - 1; i++)
      applyStimulus("clrprio", segCode[i + 1], 8'(1 << i), 1'b0, STABLE);
    applyStimulus("clrprio", segCode[15], 8'h80, 1'b0, STABLE - 1);
    applyStimulus("clrprio_edge", segCode[15], 8'h80, 1'b1, 1);
    check("clrprio.valid", 32'(bus.digit_valid), 32'd0);
    applyStimulus("clrprio_idle", segCode[15], 8'h00, 1'b0, 2);
    check("clrprio.no_frame", 32'(fdSeen), 32'd0);

    applyStimulus("midframe", segCode[10], 8'h01, 1'b0, STABLE);
    applyStimulus("midframe", segCode[11], 8'h02, 1'b0, STABLE - 2);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("async_reset");
    check("async_reset.value", bus.value, 32'd0);
    #2;
    rst_n = 1'b1;

    for (int t = 0; t < 300; t++) begin
      rs = ($urandom_range(0, 9) < 8) ? segCode[$urandom_range(0, 15)] : 7'($urandom);
      case ($urandom_range(0, 9))
        0:       rd = 8'h00;
        1:       rd = 8'($urandom);
        default: rd = 8'(1 << $urandom_range(0, DIGITS - 1));
      endcase
      rc = ($urandom_range(0, 24) == 0);
      applyStimulus("random", rs, rd, rc, $urandom_range(1, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dt_scan_decoder.md
# dt_scan_decoder

Reverse of the hex-to-digital-tube path. It watches a multiplexed seven-segment display bus: segment lines a–g plus one-hot digit selects. For each digit it waits until the pattern has been stable long enough, then decodes it back to a hex nibble, flags illegal patterns, and signals when every digit of a scan frame has been captured. It sits beside the display driver as a self-check and readback path, so the on-board test logic can compare the shown value with the intended one.

## Interface
- `DIGITS`, default 8: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a digit (≥2).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, **asynchronous and active-low**.
- `seg` input [0:6]: segment lines, `seg[0]`=a … `seg[6]`=g, active-high.
- `sel` input [DIGITS-1:0]: digit enable, active-high, expected one-hot.
- `clear` input 1: synchronous clear of captured state.
- `value` output [4*DIGITS-1:0]: captured nibbles; digit i occupies bits [4i+3:4i].
- `digit_valid` output [DIGITS-1:0]: digit captured since the last frame boundary.
- `frame_done` output 1: one-cycle pulse when all digits have been captured.
- `err` output 1: sticky; set when a stable pattern is illegal.
- `err_digit` output [2:0]: index of the most recent illegal digit.

## Operation
- Legal codes use the codebase segment map, written abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- All other 7-bit patterns are illegal, including all-off.
- **Stability tracking:**
  - One shared tracker holds `last_seg`, `last_sel` and a saturating counter `cnt` of width $clog2(STABLE_CYCLES+1).
  - On each edge: if `sel` is one-hot and (`seg`,`sel`) equals (`last_seg`,`last_sel`), `cnt` increments, saturating at STABLE_CYCLES.
  - Otherwise `cnt` := 1 when `sel` is one-hot, or 0 when it is not. `last_*` is always reloaded.
- **Commit:** happens only on the edge where `cnt` goes from STABLE_CYCLES-1 to STABLE_CYCLES. Saturation never re-commits. For the selected digit i:
  - Legal pattern: `value[i]` := decoded nibble; `digit_valid[i]` := 1.
  - Illegal pattern: `err` := 1; `err_digit` := i; `value[i]` and `digit_valid[i]` are unchanged.
- `sel` all-zero or multi-hot (blanking or overlap) never commits and restarts counting.
- **Frame:**
  - When a commit makes `digit_valid` all-ones, `frame_done` pulses high on the following cycle.
  - In that same cycle `digit_valid` clears to 0. `value` keeps its contents.
- **`clear`:** zeroes `digit_valid` and `err`, and suppresses `frame_done`. It wins over a simultaneous commit; that commit is dropped.
- A digit recaptured within a frame overwrites its nibble; `digit_valid` stays 1.

## Timing
- Reset values: `value`=0, `digit_valid`=0, `frame_done`=0, `err`=0, `err_digit`=0, `cnt`=0, `last_seg`=0, `last_sel`=0.
- Reset is asynchronous, so asserting `rst_n` mid-frame clears everything immediately. Capture resumes on the first edge after release.
- Latency: if `seg`/`sel` is constant and legal from edge k, `value`/`digit_valid` update at edge k+STABLE_CYCLES-1 and are visible after it.
- `frame_done` asserts one edge after the completing commit and is high for exactly one cycle.
- A glitch shorter than STABLE_CYCLES never reaches `value`.
- There are no combinational paths from inputs to outputs; all outputs are registered.

## Structure
- Package `dt_pkg` holds:
  - localparams SEG_0 … SEG_F (7-bit patterns);
  - SEG_W=7 and NIBBLE_W=4;
  - function `is_onehot`.
- Sub-module `dt_decoder`: combinational, `seg`[0:6] → nibble[3:0] plus `legal`. It is the inverse of the encoder table and is reused by any future readback logic.
- Top level: stability tracker, one-hot-to-index encoder, per-digit nibble registers, and the frame/err logic.

## Test plan
- **Static capture:** DIGITS=8, STABLE_CYCLES=4. Drive `sel`=8'h01 with `seg`=1101101 for 4 cycles, then step `sel` through 8'h02…8'h80 with patterns 3,4,5,6,7,8,9, 4 cycles each.
  - Expect `value`=32'h98765432.
  - Expect `frame_done` to pulse once, one cycle after the last commit, and `digit_valid`=0 afterwards.
- **Glitch reject:** hold digit 2 at 0110000 for 3 cycles, switch to 1111110 for 4 cycles.
  - Expect `value[11:8]`=0, committed only after the 4th cycle of the new pattern. Nibble 1 is never stored.
- **Illegal pattern:** `sel`=8'h10, `seg`=0000001 for 4 cycles.
  - Expect `err`=1, `err_digit`=4, `digit_valid[4]`=0, `value[19:16]` unchanged.
- **Selection faults:** `sel`=8'h00 for 10 cycles, then 8'h03 for 10 cycles, each with `seg`=1111111.
  - Expect no commit, no `err`, `cnt`=0 throughout.
- **Clear priority and reset:** assert `clear` on the exact commit edge of the 8th digit.
  - Expect no `frame_done` and `digit_valid`=0.
  - Then pull `rst_n` low mid-frame: all outputs go to 0 without waiting for a clock edge.
